io_sequencer: RTL and testbench

- Downstream consumer of the I2C register file: reads the packed 20-byte register image and plays a programmable sequence of 11-bit output words onto the chip's io_out[11:1] lanes.
- Sequencing is controlled by a step table, prescaler and dwell time, all written over I2C.
- At integration, the top level drives this block's reset port with the inverse of the chip's active-high reset.

---
 rtl/io_sequencer.sv | 132 +++++++++++++
 tb/tb_io_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_sequencer.sv
// rtl/io_sequencer.sv - plays a programmable step table from the register image onto data_out
// Step words, prescaler, dwell and control are read live from registers_packed every cycle.
module io_sequencer #(
   parameter int REGCOUNT = 20,
   parameter int OUT_W    = 11,
   parameter int STEPS    = 8,
   parameter int PAT_BASE = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [8*REGCOUNT-1:0]      registers_packed,
   output logic [OUT_W-1:0]           data_out,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(STEPS)-1:0]   step_idx
);

   localparam int SW = $clog2(STEPS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic [SW-1:0]    step_q, step_d;
   logic [7:0]       pc_q, pc_d;
   logic [7:0]       dc_q, dc_d;
   logic             start_prev_q;

   logic [7:0]       ctrl, prescale, dwell, idle_val;
   logic             en, loop_en, start, start_edge;
   logic [SW-1:0]    last_step, step_nxt;
   logic [OUT_W-1:0] idle_word;
   logic [OUT_W-1:0] words [STEPS];

   assign ctrl      = registers_packed[7:0];
   assign prescale  = registers_packed[15:8];
   assign dwell     = registers_packed[23:16];
   assign idle_val  = registers_packed[31:24];
   assign en        = ctrl[0];
   assign loop_en   = ctrl[1];
   assign start     = ctrl[2];
   assign last_step = SW'(ctrl[6:4]);
   assign idle_word = {{(OUT_W-8){1'b0}}, idle_val};
   assign step_nxt  = step_q + SW'(1);
   assign start_edge = start & ~start_prev_q;

   // Only the low OUT_W-8 bits of each high byte belong to the step word.
   for (genvar k = 0; k < STEPS; k++) begin : g_words
      assign words[k] = {registers_packed[8*(PAT_BASE+2*k+1) +: (OUT_W-8)],
                         registers_packed[8*(PAT_BASE+2*k) +: 8]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         data_q       <= '0;
         step_q       <= '0;
         pc_q         <= '0;
         dc_q         <= '0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         step_q       <= step_d;
         pc_q         <= pc_d;
         dc_q         <= dc_d;
         start_prev_q <= start;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      step_d  = step_q;
      pc_d    = pc_q;
      dc_d    = dc_q;

      if (!en) begin
         state_d = S_IDLE;
         data_d  = idle_word;
         step_d  = '0;
         pc_d    = '0;
         dc_d    = '0;
      end else if (start_edge) begin
         // A fresh START edge (re)launches from step 0 in every state.
         state_d = S_RUN;
         data_d  = words[0];
         step_d  = '0;
         pc_d    = '0;
         dc_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: data_d = idle_word;
            S_RUN: begin
               data_d = words[step_q];
               // >= lets a shrunken P or D end the count at once instead of wrapping.
               if (pc_q >= prescale) begin
                  pc_d = '0;
                  if (dc_q >= dwell) begin
                     dc_d = '0;
                     if (step_q != last_step) begin
                        step_d = step_nxt;
                        data_d = words[step_nxt];
                     end else if (loop_en) begin
                        step_d = '0;
                        data_d = words[0];
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     dc_d = dc_q + 8'd1;
                  end
               end else begin
                  pc_d = pc_q + 8'd1;
               end
            end
            S_DONE:  data_d = data_q;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign data_out = data_q;
   assign step_idx = step_q;
   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_io_sequencer.sv
// tb/tb_io_sequencer.sv - self-checking bench for io_sequencer
module tb_io_sequencer;
   localparam int REGCOUNT = 20;
   localparam int OUT_W    = 11;
   localparam int STEPS    = 8;
   localparam int PAT_BASE = 4;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic [8*REGCOUNT-1:0] registers_packed;
   logic [OUT_W-1:0]      data_out;
   logic                  busy;
   logic                  done;
   logic [2:0]            step_idx;
   logic [7:0]            regs [REGCOUNT];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [10:0] data;
      logic        busy;
      logic        done;
      logic [2:0]  step;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0] p;
      logic [7:0] d;
      logic [2:0] last;
      int         exp_busy;
   } vec_t;
   vec_t vecs[7];

   io_sequencer #(
      .REGCOUNT(REGCOUNT), .OUT_W(OUT_W), .STEPS(STEPS), .PAT_BASE(PAT_BASE)
   ) dut (
      .clock(clock),
      .reset(reset),
      .registers_packed(registers_packed),
      .data_out(data_out),
      .busy(busy),
      .done(done),
      .step_idx(step_idx)
   );

   always #5 clock = ~clock;

   always_comb begin
      registers_packed = '0;
      for (int i = 0; i < REGCOUNT; i++) registers_packed[8*i +: 8] = regs[i];
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_ctrl(input logic en, input logic lp, input logic st, input logic [2:0] last);
      regs[0] = {1'b1, last, 1'b1, st, lp, en};
   endtask

   task automatic set_step(input int k, input logic [10:0] w);
      regs[PAT_BASE+2*k]   = w[7:0];
      regs[PAT_BASE+2*k+1] = {5'b10101, w[10:8]};
   endtask

   task automatic push(input logic [10:0] d, input logic b, input logic dn, input logic [2:0] s);
      exp_t e;
      e.data = d; e.busy = b; e.done = dn; e.step = s;
      sb.push_back(e);
   endtask

   task automatic drain(input string nm);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tick();
         chk({nm, "_data"}, 32'(data_out), 32'(e.data));
         chk({nm, "_busy"}, 32'(busy), 32'(e.busy));
         chk({nm, "_done"}, 32'(done), 32'(e.done));
         chk({nm, "_step"}, 32'(step_idx), 32'(e.step));
      end
   endtask

   task automatic go_idle();
      set_ctrl(1'b0, 1'b0, 1'b0, 3'd0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      vecs[0] = '{8'd1,   8'd2, 3'd2, 18};
      vecs[1] = '{8'd0,   8'd0, 3'd0, 1};
      vecs[2] = '{8'd2,   8'd1, 3'd1, 12};
      vecs[3] = '{8'd0,   8'd3, 3'd3, 16};
      vecs[4] = '{8'd255, 8'd0, 3'd0, 256};
      vecs[5] = '{8'd0,   8'd0, 3'd7, 8};
      vecs[6] = '{8'd4,   8'd0, 3'd5, 30};

      for (int i = 0; i < REGCOUNT; i++) regs[i] = 8'h00;
      regs[3] = 8'h5A;
      set_ctrl(1'b0, 1'b0, 1'b0, 3'd0);

      // reset state and release
      #2;
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_step", 32'(step_idx), 32'h0);
      tick(); tick();
      chk("rst_hold_data", 32'(data_out), 32'h0);
      reset = 1'b1;
      tick();
      chk("rel_idle_data", 32'(data_out), 32'h05A);

      // three-step one-shot, START held high throughout
      go_idle();
      regs[1] = 8'd1; regs[2] = 8'd2;
      set_step(0, 11'h001); set_step(1, 11'h002); set_step(2, 11'h7FF);
      set_ctrl(1'b1, 1'b0, 1'b0, 3'd2);
      tick();
      set_ctrl(1'b1, 1'b0, 1'b1, 3'd2);
      for (int k = 0; k < 18; k++)
         push((k < 6) ? 11'h001 : (k < 12) ? 11'h002 : 11'h7FF, 1'b1, 1'b0, 3'(k / 6));
      for (int k = 0; k < 4; k++) push(11'h7FF, 1'b0, 1'b1, 3'd2);
      drain("oneshot");

      // restart from DONE, then restart mid-run
      set_ctrl(1'b1, 1'b0, 1'b0, 3'd2);
      tick();
      set_ctrl(1'b1, 1'b0, 1'b1, 3'd2);
      tick();
      chk("done_restart_busy", 32'(busy), 32'h1);
      chk("done_restart_step", 32'(step_idx), 32'h0);
      chk("done_restart_data", 32'(data_out), 32'h001);
      repeat (7) tick();
      chk("run_step1", 32'(step_idx), 32'h1);
      set_ctrl(1'b1, 1'b0, 1'b0, 3'd2);
      tick();
      set_ctrl(1'b1, 1'b0, 1'b1, 3'd2);
      tick();
      chk("run_restart_step", 32'(step_idx), 32'h0);
      chk("run_restart_busy", 32'(busy), 32'h1);
      tick();
      chk("run_restart_data", 32'(data_out), 32'h001);

      // two-step loop at full rate
      go_idle();
      regs[1] = 8'd0; regs[2] = 8'd0;
      set_step(0, 11'h155); set_step(1, 11'h2AA);
      set_ctrl(1'b1, 1'b1, 1'b0, 3'd1);
      tick();
      set_ctrl(1'b1, 1'b1, 1'b1, 3'd1);
      for (int k = 0; k < 12; k++)
         push((k % 2 == 0) ? 11'h155 : 11'h2AA, 1'b1, 1'b0, 3'(k % 2));
      drain("loop");

      for (int k = 0; k < STEPS; k++) set_step(k, 11'h100 + 11'(k));

      // EN dropped during step 1
      go_idle();
      regs[1] = 8'd3; regs[2] = 8'd3;
      set_ctrl(1'b1, 1'b0, 1'b0, 3'd3);
      tick();
      set_ctrl(1'b1, 1'b0, 1'b1, 3'd3);
      tick();
      repeat (18) tick();
      chk("en_pre_step", 32'(step_idx), 32'h1);
      set_ctrl(1'b0, 1'b0, 1'b1, 3'd3);
      tick();
      chk("en_off_data", 32'(data_out), 32'h05A);
      chk("en_off_busy", 32'(busy), 32'h0);
      chk("en_off_step", 32'(step_idx), 32'h0);
      chk("en_off_done", 32'(done), 32'h0);

      // sequence length table: (P+1)*(D+1)*(LAST+1)
      for (int v = 0; v < 7; v++) begin
         go_idle();
         regs[1] = vecs[v].p; regs[2] = vecs[v].d;
         set_ctrl(1'b1, 1'b0, 1'b0, vecs[v].last);
         tick();
         set_ctrl(1'b1, 1'b0, 1'b1, vecs[v].last);
         cnt = 0;
         for (int c = 0; c < 3000; c++) begin
            tick();
            if (!busy) break;
            cnt++;
         end
         chk($sformatf("tbl%0d_busy_cycles", v), 32'(cnt), 32'(vecs[v].exp_busy));
         chk($sformatf("tbl%0d_done", v), 32'(done), 32'h1);
         chk($sformatf("tbl%0d_data", v), 32'(data_out), 32'h100 + 32'(vecs[v].last));
         chk($sformatf("tbl%0d_step", v), 32'(step_idx), 32'(vecs[v].last));
      end

      // LAST moved below current step: wraps through 7 -> 0 before ending
      go_idle();
      regs[1] = 8'd0; regs[2] = 8'd0;
      set_ctrl(1'b1, 1'b0, 1'b0, 3'd7);
      tick();
      set_ctrl(1'b1, 1'b0, 1'b1, 3'd7);
      tick();
      repeat (3) tick();
      chk("wrap_pre_step", 32'(step_idx), 32'h3);
      set_ctrl(1'b1, 1'b0, 1'b1, 3'd1);
      cnt = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (!busy) break;
         cnt++;
      end
      chk("wrap_busy_cycles", 32'(cnt), 32'd6);
      chk("wrap_done", 32'(done), 32'h1);
      chk("wrap_step", 32'(step_idx), 32'h1);

      // prescale shrunk mid-count ends the step at once
      go_idle();
      regs[1] = 8'd10; regs[2] = 8'd0;
      set_ctrl(1'b1, 1'b0, 1'b0, 3'd1);
      tick();
      set_ctrl(1'b1, 1'b0, 1'b1, 3'd1);
      tick();
      repeat (8) tick();
      chk("pshrink_pre_step", 32'(step_idx), 32'h0);
      regs[1] = 8'd2;
      tick();
      chk("pshrink_step", 32'(step_idx), 32'h1);
      chk("pshrink_data", 32'(data_out), 32'h101);

      // asynchronous reset mid-run, no clock edge needed
      #3 reset = 1'b0;
      #1;
      chk("async_rst_data", 32'(data_out), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_step", 32'(step_idx), 32'h0);
      set_ctrl(1'b1, 1'b0, 1'b0, 3'd1);
      tick();
      reset = 1'b1;
      tick();
      chk("async_rel_data", 32'(data_out), 32'h05A);
      chk("async_rel_busy", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
